// File: rtl/uv_sram_bus_arb_if.sv
// Request/response bus shared by the SRAM requesters and the SRAM bus controller.
// The master modport is the side that issues requests; the slave modport serves them.
interface uv_sram_bus_arb_if #(
  parameter int ALEN = 32,
  parameter int DLEN = 32,
  parameter int MLEN = DLEN / 8
);
  logic            req_vld;
  logic            req_rdy;
  logic            req_read;
  logic [ALEN-1:0] req_addr;
  logic [MLEN-1:0] req_mask;
  logic [DLEN-1:0] req_data;
  logic            rsp_vld;
  logic            rsp_rdy;
  logic [1:0]      rsp_excp;
  logic [DLEN-1:0] rsp_data;

  modport master (
    output req_vld, req_read, req_addr, req_mask, req_data, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_excp, rsp_data
  );

  modport slave (
    input  req_vld, req_read, req_addr, req_mask, req_data, rsp_rdy,
    output req_rdy, rsp_vld, rsp_excp, rsp_data
  );
endinterface

// File: rtl/uv_sram_bus_arb.sv
// Two-requester round-robin arbiter in front of one SRAM bus controller, with an ID FIFO
// routing in-order responses back to their issuer. `UV_SRAM_ARB_FIXED_PRI_EN makes m0 always win.
module uv_sram_bus_arb #(
  parameter int ALEN      = 32,
  parameter int DLEN      = 32,
  parameter int MLEN      = DLEN / 8,
  parameter int OST_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  uv_sram_bus_arb_if.slave   m0,
  uv_sram_bus_arb_if.slave   m1,
  uv_sram_bus_arb_if.master  s
);

  localparam int PTR_W = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic             lock_q, lock_d;
  logic             lock_id_q, lock_id_d;
`ifndef UV_SRAM_ARB_FIXED_PRI_EN
  logic             rr_ptr_q, rr_ptr_d;
`endif
  logic [OST_DEPTH-1:0] id_mem_q, id_mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             grant_id;
  logic             gnt_vld;
  logic             gnt_read;
  logic [ALEN-1:0]  gnt_addr;
  logic [MLEN-1:0]  gnt_mask;
  logic [DLEN-1:0]  gnt_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             req_fire;
  logic             rsp_fire;
  logic             head_id;
  logic             rsp_ok;

  assign fifo_full  = (cnt_q == CNT_W'(OST_DEPTH));
  assign fifo_empty = (cnt_q == '0);

  // A locked (stalled) request keeps its master; otherwise a lone requester wins outright.
  always_comb begin
    grant_id = 1'b0;
    if (lock_q) begin
      grant_id = lock_id_q;
    end else if (m0.req_vld && m1.req_vld) begin
`ifdef UV_SRAM_ARB_FIXED_PRI_EN
      grant_id = 1'b0;
`else
      grant_id = rr_ptr_q;
`endif
    end else if (m1.req_vld) begin
      grant_id = 1'b1;
    end
  end

  always_comb begin
    gnt_vld  = m0.req_vld;
    gnt_read = m0.req_read;
    gnt_addr = m0.req_addr;
    gnt_mask = m0.req_mask;
    gnt_data = m0.req_data;
    if (grant_id) begin
      gnt_vld  = m1.req_vld;
      gnt_read = m1.req_read;
      gnt_addr = m1.req_addr;
      gnt_mask = m1.req_mask;
      gnt_data = m1.req_data;
    end
  end

  // rst_n gates handshakes so every vld/rdy output drops as soon as reset asserts.
  assign s.req_vld  = rst_n & gnt_vld & ~fifo_full;
  assign s.req_read = gnt_read;
  assign s.req_addr = gnt_addr;
  assign s.req_mask = gnt_mask;
  assign s.req_data = gnt_data;
  assign m0.req_rdy = rst_n & ~grant_id & s.req_rdy & ~fifo_full;
  assign m1.req_rdy = rst_n &  grant_id & s.req_rdy & ~fifo_full;
  assign req_fire   = s.req_vld & s.req_rdy;

  assign head_id    = id_mem_q[rd_ptr_q];
  assign rsp_ok     = rst_n & ~fifo_empty;
  assign m0.rsp_vld = rsp_ok & s.rsp_vld & ~head_id;
  assign m1.rsp_vld = rsp_ok & s.rsp_vld &  head_id;
  assign s.rsp_rdy  = rsp_ok & (head_id ? m1.rsp_rdy : m0.rsp_rdy);
  assign m0.rsp_excp = s.rsp_excp;
  assign m0.rsp_data = s.rsp_data;
  assign m1.rsp_excp = s.rsp_excp;
  assign m1.rsp_data = s.rsp_data;
  assign rsp_fire   = s.rsp_vld & s.rsp_rdy;

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (req_fire) begin
      lock_d = 1'b0;
    end else if (s.req_vld) begin
      lock_d    = 1'b1;
      lock_id_d = grant_id;
    end
  end

`ifndef UV_SRAM_ARB_FIXED_PRI_EN
  assign rr_ptr_d = req_fire ? ~grant_id : rr_ptr_q;
`endif

  // Full FIFO blocks new grants, so push never collides with a full condition.
  always_comb begin
    id_mem_d = id_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (req_fire) begin
      id_mem_d[wr_ptr_q] = grant_id;
      wr_ptr_d           = wr_ptr_q + PTR_W'(1);
    end
    if (rsp_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
`ifndef UV_SRAM_ARB_FIXED_PRI_EN
      rr_ptr_q  <= 1'b0;
`endif
      id_mem_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
`ifndef UV_SRAM_ARB_FIXED_PRI_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
      id_mem_q  <= id_mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && s.rsp_vld && fifo_empty) begin
      $display("uv_sram_bus_arb: response with no outstanding request dropped at %0t", $time);
    end
  end
`endif

endmodule

// File: tb/tb_uv_sram_bus_arb.sv
// Directed bench for uv_sram_bus_arb: single grant, alternation, stall lock, full FIFO,
// in-order response blocking and asynchronous reset.
module tb_uv_sram_bus_arb;

`ifdef UV_SRAM_ARB_FIXED_PRI_EN
  localparam logic FIXED = 1'b1;
`else
  localparam logic FIXED = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  uv_sram_bus_arb_if #(.ALEN(32), .DLEN(32), .MLEN(4)) m0_bus ();
  uv_sram_bus_arb_if #(.ALEN(32), .DLEN(32), .MLEN(4)) m1_bus ();
  uv_sram_bus_arb_if #(.ALEN(32), .DLEN(32), .MLEN(4)) s_bus ();

  uv_sram_bus_arb #(.ALEN(32), .DLEN(32), .MLEN(4), .OST_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic m0v, input logic m1v, input logic [31:0] m1a,
                               input logic srdy, input logic srspv, input logic [31:0] rdata,
                               input logic m0rr, input logic m1rr);
    @(negedge clk);
    m0_bus.req_vld  = m0v;
    m1_bus.req_vld  = m1v;
    m1_bus.req_addr = m1a;
    s_bus.req_rdy   = srdy;
    s_bus.rsp_vld   = srspv;
    s_bus.rsp_data  = rdata;
    m0_bus.rsp_rdy  = m0rr;
    m1_bus.rsp_rdy  = m1rr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    checks = 0;
    failures = 0;
    m0_bus.req_vld = 0; m0_bus.req_read = 0; m0_bus.req_addr = 32'h100;
    m0_bus.req_mask = 4'h3; m0_bus.req_data = 32'hD0; m0_bus.rsp_rdy = 0;
    m1_bus.req_vld = 0; m1_bus.req_read = 1; m1_bus.req_addr = 32'h200;
    m1_bus.req_mask = 4'hC; m1_bus.req_data = 32'hD1; m1_bus.rsp_rdy = 0;
    s_bus.req_rdy = 0; s_bus.rsp_vld = 0; s_bus.rsp_excp = 2'b01; s_bus.rsp_data = 0;

    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_s_req_vld", s_bus.req_vld, 0);
    checkOutput("rst_m0_req_rdy", m0_bus.req_rdy, 0);
    checkOutput("rst_m1_req_rdy", m1_bus.req_rdy, 0);
    checkOutput("rst_s_rsp_rdy", s_bus.rsp_rdy, 0);
    rst_n = 1'b1;

    $display("[TB] single m1 read");
    applyStimulus(0, 1, 32'h10, 1, 0, 0, 1, 1);
    checkOutput("t1_m1_req_rdy", m1_bus.req_rdy, 1);
    checkOutput("t1_m0_req_rdy", m0_bus.req_rdy, 0);
    checkOutput("t1_s_req_addr", s_bus.req_addr, 32'h10);
    checkOutput("t1_s_req_read", s_bus.req_read, 1);
    checkOutput("t1_s_req_mask", s_bus.req_mask, 4'hC);
    checkOutput("t1_s_req_data", s_bus.req_data, 32'hD1);
    applyStimulus(0, 0, 32'h200, 1, 1, 32'hA5A5A5A5, 1, 1);
    checkOutput("t1_m1_rsp_vld", m1_bus.rsp_vld, 1);
    checkOutput("t1_m1_rsp_data", m1_bus.rsp_data, 32'hA5A5A5A5);
    checkOutput("t1_m0_rsp_vld", m0_bus.rsp_vld, 0);
    checkOutput("t1_m0_rsp_excp", m0_bus.rsp_excp, 2'b01);
    checkOutput("t1_s_rsp_rdy", s_bus.rsp_rdy, 1);

    $display("[TB] both valid, slave always ready");
    applyStimulus(1, 1, 32'h200, 1, 0, 0, 1, 1);
    checkOutput("t2_c0_addr", s_bus.req_addr, 32'h100);
    checkOutput("t2_c0_read", s_bus.req_read, 0);
    checkOutput("t2_c0_mask", s_bus.req_mask, 4'h3);
    applyStimulus(1, 1, 32'h200, 1, 1, 32'h11, 1, 1);
    checkOutput("t2_c1_addr", s_bus.req_addr, FIXED ? 32'h100 : 32'h200);
    checkOutput("t2_c1_m0_rsp_vld", m0_bus.rsp_vld, 1);
    applyStimulus(1, 1, 32'h200, 1, 1, 32'h22, 1, 1);
    checkOutput("t2_c2_addr", s_bus.req_addr, 32'h100);
    checkOutput("t2_c2_m1_rsp_vld", m1_bus.rsp_vld, FIXED ? 1'b0 : 1'b1);
    applyStimulus(1, 1, 32'h200, 1, 1, 32'h33, 1, 1);
    checkOutput("t2_c3_addr", s_bus.req_addr, FIXED ? 32'h100 : 32'h200);
    checkOutput("t2_c3_m1_req_rdy", m1_bus.req_rdy, FIXED ? 1'b0 : 1'b1);
    applyStimulus(0, 0, 32'h200, 1, 1, 32'h44, 1, 1);
    checkOutput("t2_drain_rsp_rdy", s_bus.rsp_rdy, 1);

    $display("[TB] m1 stalled while m0 waits");
    applyStimulus(0, 1, 32'h200, 0, 0, 0, 1, 1);
    checkOutput("t3_c0_addr", s_bus.req_addr, 32'h200);
    applyStimulus(1, 1, 32'h200, 0, 0, 0, 1, 1);
    checkOutput("t3_c1_addr", s_bus.req_addr, 32'h200);
    checkOutput("t3_c1_m0_req_rdy", m0_bus.req_rdy, 0);
    applyStimulus(1, 1, 32'h200, 0, 0, 0, 1, 1);
    checkOutput("t3_c2_addr", s_bus.req_addr, 32'h200);
    applyStimulus(1, 1, 32'h200, 1, 0, 0, 1, 1);
    checkOutput("t3_c3_addr", s_bus.req_addr, 32'h200);
    checkOutput("t3_c3_m1_req_rdy", m1_bus.req_rdy, 1);
    checkOutput("t3_c3_m0_req_rdy", m0_bus.req_rdy, 0);
    applyStimulus(1, 0, 32'h200, 1, 0, 0, 1, 1);
    checkOutput("t3_c4_addr", s_bus.req_addr, 32'h100);
    checkOutput("t3_c4_m0_req_rdy", m0_bus.req_rdy, 1);
    applyStimulus(0, 0, 32'h200, 1, 1, 32'h55, 1, 1);
    checkOutput("t3_c5_m1_rsp_vld", m1_bus.rsp_vld, 1);
    checkOutput("t3_c5_m0_rsp_vld", m0_bus.rsp_vld, 0);
    applyStimulus(0, 0, 32'h200, 1, 1, 32'h66, 1, 1);
    checkOutput("t3_c6_m0_rsp_vld", m0_bus.rsp_vld, 1);
    applyStimulus(0, 0, 32'h200, 1, 0, 0, 1, 1);

    $display("[TB] outstanding limit");
    applyStimulus(1, 1, 32'h200, 1, 0, 0, 1, 1);
    checkOutput("t4_c0_addr", s_bus.req_addr, FIXED ? 32'h100 : 32'h200);
    applyStimulus(1, 1, 32'h200, 1, 0, 0, 1, 1);
    checkOutput("t4_c1_addr", s_bus.req_addr, 32'h100);
    applyStimulus(1, 1, 32'h200, 1, 0, 0, 1, 1);
    checkOutput("t4_full_s_req_vld", s_bus.req_vld, 0);
    checkOutput("t4_full_m0_req_rdy", m0_bus.req_rdy, 0);
    checkOutput("t4_full_m1_req_rdy", m1_bus.req_rdy, 0);
    applyStimulus(1, 1, 32'h200, 1, 1, 32'h77, 1, 1);
    checkOutput("t4_pop_no_bypass", s_bus.req_vld, 0);
    checkOutput("t4_pop_m1_rsp_vld", m1_bus.rsp_vld, FIXED ? 1'b0 : 1'b1);
    checkOutput("t4_pop_m0_rsp_vld", m0_bus.rsp_vld, FIXED ? 1'b1 : 1'b0);
    applyStimulus(1, 1, 32'h200, 1, 0, 0, 1, 1);
    checkOutput("t4_regrant_vld", s_bus.req_vld, 1);
    checkOutput("t4_regrant_addr", s_bus.req_addr, FIXED ? 32'h100 : 32'h200);
    applyStimulus(0, 0, 32'h200, 1, 1, 32'h88, 1, 1);
    applyStimulus(0, 0, 32'h200, 1, 1, 32'h99, 1, 1);
    checkOutput("t4_drain_rsp_rdy", s_bus.rsp_rdy, 1);
    applyStimulus(0, 0, 32'h200, 1, 0, 0, 1, 1);

    $display("[TB] in-order response blocking");
    applyStimulus(1, 0, 32'h200, 1, 0, 0, 0, 1);
    checkOutput("t5_m0_req_rdy", m0_bus.req_rdy, 1);
    applyStimulus(0, 1, 32'h200, 1, 0, 0, 0, 1);
    checkOutput("t5_m1_req_rdy", m1_bus.req_rdy, 1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 32'h200, 1, 1, 32'hC0DE0000, 0, 1);
      checkOutput("t5_block_m0_rsp_vld", m0_bus.rsp_vld, 1);
      checkOutput("t5_block_s_rsp_rdy", s_bus.rsp_rdy, 0);
      checkOutput("t5_block_m1_rsp_vld", m1_bus.rsp_vld, 0);
    end
    applyStimulus(0, 0, 32'h200, 1, 1, 32'hC0DE0000, 1, 1);
    checkOutput("t5_m0_fire_rdy", s_bus.rsp_rdy, 1);
    applyStimulus(0, 0, 32'h200, 1, 1, 32'h5A5A5A5A, 1, 1);
    checkOutput("t5_m1_rsp_vld", m1_bus.rsp_vld, 1);
    checkOutput("t5_m1_rsp_data", m1_bus.rsp_data, 32'h5A5A5A5A);
    checkOutput("t5_m0_rsp_vld_after", m0_bus.rsp_vld, 0);
    applyStimulus(0, 0, 32'h200, 1, 0, 0, 1, 1);

    $display("[TB] asynchronous reset with lock and outstanding request");
    applyStimulus(1, 0, 32'h200, 1, 0, 0, 1, 1);
    applyStimulus(0, 1, 32'h200, 0, 0, 0, 1, 1);
    applyStimulus(1, 1, 32'h200, 0, 1, 32'h1234, 1, 1);
    checkOutput("t6_locked_addr", s_bus.req_addr, 32'h200);
    checkOutput("t6_pre_m0_rsp_vld", m0_bus.rsp_vld, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_s_req_vld", s_bus.req_vld, 0);
    checkOutput("t6_rst_m0_req_rdy", m0_bus.req_rdy, 0);
    checkOutput("t6_rst_m1_req_rdy", m1_bus.req_rdy, 0);
    checkOutput("t6_rst_m0_rsp_vld", m0_bus.rsp_vld, 0);
    checkOutput("t6_rst_m1_rsp_vld", m1_bus.rsp_vld, 0);
    checkOutput("t6_rst_s_rsp_rdy", s_bus.rsp_rdy, 0);
    applyStimulus(1, 1, 32'h200, 0, 0, 0, 1, 1);
    rst_n = 1'b1;
    #1;
    checkOutput("t6_post_addr", s_bus.req_addr, 32'h100);
    checkOutput("t6_post_s_req_vld", s_bus.req_vld, 1);
    checkOutput("t6_post_s_rsp_rdy", s_bus.rsp_rdy, 0);
    applyStimulus(0, 0, 32'h200, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
